// File: rtl/pipe_stall_ctl.sv
// pipe_stall_ctl: stall/flush sequencer for the 5-stage pipeline, owning the MDU and dmem-timeout counters
module pipe_stall_ctl #(
   parameter int MUL_CYCLES  = 4,
   parameter int DIV_CYCLES  = 32,
   parameter int MEM_TIMEOUT = 64,
   parameter int CW          = 8
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       d_available,
   input  logic       imem_ready,
   input  logic       e_mdu_start,
   input  logic       e_mdu_div,
   input  logic       m_mem_req,
   input  logic       dmem_ready,
   input  logic       m_exc,
   output logic       f_en,
   output logic       fd_en,
   output logic       fd_flush,
   output logic       de_en,
   output logic       de_bubble,
   output logic       em_en,
   output logic       em_bubble,
   output logic       mw_en,
   output logic       mw_bubble,
   output logic       exc_flush,
   output logic       bus_err,
   output logic       mdu_busy,
   output logic       mdu_done,
   output logic [1:0] state
);
   typedef enum logic [1:0] {RUN = 2'd0, MDU = 2'd1, MEM = 2'd2, ERR = 2'd3} state_t;

   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);
   localparam logic [CW-1:0] MEM_LAST = CW'(MEM_TIMEOUT - 1);

   if (MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_mdu
      $error("MUL_CYCLES and DIV_CYCLES must be >= 1");
   end
   if (MEM_TIMEOUT < 2) begin : g_bad_timeout
      $error("MEM_TIMEOUT must be >= 2");
   end
   if (DIV_CYCLES > (1 << CW) - 1 || MUL_CYCLES > (1 << CW) - 1 || MEM_TIMEOUT > (1 << CW) - 1) begin : g_bad_cw
      $error("CW too narrow for cycle counts");
   end

   state_t        st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] issue_cnt;
   logic          hold_e, mem_freeze, full_flush, df_rules;

   assign issue_cnt = e_mdu_div ? DIV_LAST : MUL_LAST;
   assign state     = st_q;

   // state and counter register, aborted immediately by reset
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         st_q  <= RUN;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end

   // next-state selection, then per-stage enable/bubble decode from the chosen action
   always_comb begin
      st_d       = st_q;
      cnt_d      = cnt_q;
      hold_e     = 1'b0;
      mem_freeze = 1'b0;
      full_flush = 1'b0;
      df_rules   = 1'b0;
      bus_err    = 1'b0;
      mdu_busy   = 1'b0;
      mdu_done   = 1'b0;
      case (st_q)
         RUN: begin
            if (m_exc) begin
               full_flush = 1'b1;
               cnt_d      = '0;
            end else if (m_mem_req && !dmem_ready) begin
               mem_freeze = 1'b1;
               st_d       = MEM;
               cnt_d      = CW'(1);
            end else if (e_mdu_start) begin
               mdu_busy = 1'b1;
               if (issue_cnt == '0) mdu_done = 1'b1;
               else begin
                  hold_e = 1'b1;
                  st_d   = MDU;
                  cnt_d  = issue_cnt - 1'b1;
               end
            end else df_rules = 1'b1;
         end
         MDU: begin
            mdu_busy = 1'b1;
            if (cnt_q != '0) begin
               hold_e = 1'b1;
               cnt_d  = cnt_q - 1'b1;
            end else begin
               mdu_done = 1'b1;
               df_rules = 1'b1;
               st_d     = RUN;
            end
         end
         MEM: begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            if (dmem_ready) begin
               st_d  = RUN;
               cnt_d = '0;
            end else begin
               mem_freeze = 1'b1;
               if (cnt_q == MEM_LAST) begin
                  bus_err = 1'b1;
                  st_d    = ERR;
               end
            end
         end
         ERR: begin
            full_flush = 1'b1;
            st_d       = RUN;
            cnt_d      = '0;
         end
      endcase
      f_en      = 1'b1;
      fd_en     = 1'b1;
      de_en     = 1'b1;
      em_en     = 1'b1;
      mw_en     = 1'b1;
      fd_flush  = full_flush;
      de_bubble = full_flush;
      em_bubble = full_flush;
      mw_bubble = full_flush;
      exc_flush = full_flush;
      if (mem_freeze) begin
         f_en      = 1'b0;
         fd_en     = 1'b0;
         de_en     = 1'b0;
         em_en     = 1'b0;
         mw_bubble = 1'b1;
      end
      if (hold_e) begin
         f_en      = 1'b0;
         fd_en     = 1'b0;
         de_en     = 1'b0;
         em_bubble = 1'b1;
      end
      if (df_rules && !d_available) begin
         f_en      = 1'b0;
         fd_en     = 1'b0;
         de_bubble = 1'b1;
      end else if (df_rules && !imem_ready) begin
         f_en     = 1'b0;
         fd_flush = 1'b1;
      end
      if (!clrn) begin
         f_en      = 1'b0;
         fd_en     = 1'b0;
         de_en     = 1'b0;
         em_en     = 1'b0;
         mw_en     = 1'b0;
         fd_flush  = 1'b1;
         de_bubble = 1'b1;
         em_bubble = 1'b1;
         mw_bubble = 1'b1;
         exc_flush = 1'b0;
         bus_err   = 1'b0;
         mdu_busy  = 1'b0;
         mdu_done  = 1'b0;
      end
   end
endmodule

// File: tb/tb_pipe_stall_ctl.sv
// tb_pipe_stall_ctl: directed self-checking bench for pipe_stall_ctl
module tb_pipe_stall_ctl;
   logic       clk = 1'b0;
   logic       clrn, d_available, imem_ready, e_mdu_start, e_mdu_div, m_mem_req, dmem_ready, m_exc;
   logic       f_en, fd_en, fd_flush, de_en, de_bubble, em_en, em_bubble, mw_en, mw_bubble;
   logic       exc_flush, bus_err, mdu_busy, mdu_done;
   logic [1:0] state;
   logic [4:0] en;
   logic [3:0] bub;
   int         checks = 0;
   int         failures = 0;

   assign en  = {f_en, fd_en, de_en, em_en, mw_en};
   assign bub = {fd_flush, de_bubble, em_bubble, mw_bubble};

   always #5 clk = ~clk;

   pipe_stall_ctl dut (
      .clk(clk), .clrn(clrn), .d_available(d_available), .imem_ready(imem_ready),
      .e_mdu_start(e_mdu_start), .e_mdu_div(e_mdu_div), .m_mem_req(m_mem_req),
      .dmem_ready(dmem_ready), .m_exc(m_exc), .f_en(f_en), .fd_en(fd_en), .fd_flush(fd_flush),
      .de_en(de_en), .de_bubble(de_bubble), .em_en(em_en), .em_bubble(em_bubble), .mw_en(mw_en),
      .mw_bubble(mw_bubble), .exc_flush(exc_flush), .bus_err(bus_err), .mdu_busy(mdu_busy),
      .mdu_done(mdu_done), .state(state)
   );

   task automatic idle_inputs;
      d_available = 1'b1;
      imem_ready  = 1'b1;
      e_mdu_start = 1'b0;
      e_mdu_div   = 1'b0;
      m_mem_req   = 1'b0;
      dmem_ready  = 1'b0;
      m_exc       = 1'b0;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      idle_inputs();
      e_mdu_start = 1'b1;
      clrn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (en !== 5'b00000 || bub !== 4'b1111) begin
            failures++;
            $display("FAIL reset_outputs cyc=%0d en=%b bub=%b expected en=00000 bub=1111", i, en, bub);
         end
         checks++;
         if ({exc_flush, bus_err, mdu_busy, mdu_done, state} !== 6'b0) begin
            failures++;
            $display("FAIL reset_misc cyc=%0d got=%b expected=000000", i, {exc_flush, bus_err, mdu_busy, mdu_done, state});
         end
         tick();
      end
      clrn = 1'b1;
      e_mdu_start = 1'b0;
      @(negedge clk);
      checks++;
      if (state !== 2'd0 || en !== 5'b11111 || bub !== 4'b0000) begin
         failures++;
         $display("FAIL reset_release state=%0d en=%b bub=%b expected 0 11111 0000", state, en, bub);
      end
      tick();
   endtask

   task automatic test_mul;
      idle_inputs();
      e_mdu_start = 1'b1;
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         checks++;
         if (c <= 2) begin
            if (f_en !== 1'b0 || em_bubble !== 1'b1 || mdu_done !== 1'b0 || mdu_busy !== 1'b1 || en !== 5'b00011 || state !== (c == 0 ? 2'd0 : 2'd1)) begin
               failures++;
               $display("FAIL mul_hold c=%0d en=%b em_bubble=%b done=%b busy=%b state=%0d", c, en, em_bubble, mdu_done, mdu_busy, state);
            end
         end else if (c == 3) begin
            if (mdu_done !== 1'b1 || en !== 5'b11111 || bub !== 4'b0000 || state !== 2'd1) begin
               failures++;
               $display("FAIL mul_done done=%b en=%b bub=%b state=%0d expected 1 11111 0000 1", mdu_done, en, bub, state);
            end
         end else if (state !== 2'd0 || mdu_busy !== 1'b0) begin
            failures++;
            $display("FAIL mul_after state=%0d busy=%b expected 0 0", state, mdu_busy);
         end
         tick();
         e_mdu_start = 1'b0;
      end
   endtask

   task automatic test_div;
      idle_inputs();
      e_mdu_start = 1'b1;
      e_mdu_div   = 1'b1;
      for (int c = 0; c <= 32; c++) begin
         if (c == 31) d_available = 1'b0;
         if (c == 32) d_available = 1'b1;
         @(negedge clk);
         checks++;
         if (c < 31) begin
            if (mdu_done !== 1'b0 || em_bubble !== 1'b1 || f_en !== 1'b0) begin
               failures++;
               $display("FAIL div_hold c=%0d done=%b em_bubble=%b f_en=%b", c, mdu_done, em_bubble, f_en);
            end
         end else if (c == 31) begin
            if (mdu_done !== 1'b1 || en !== 5'b00111 || bub !== 4'b0100) begin
               failures++;
               $display("FAIL div_done_hazard done=%b en=%b bub=%b expected 1 00111 0100", mdu_done, en, bub);
            end
         end else if (state !== 2'd0 || mdu_busy !== 1'b0) begin
            failures++;
            $display("FAIL div_after state=%0d busy=%b expected 0 0", state, mdu_busy);
         end
         tick();
         e_mdu_start = 1'b0;
         e_mdu_div   = 1'b0;
      end
   endtask

   task automatic test_mem_wait;
      idle_inputs();
      m_mem_req = 1'b1;
      for (int c = 0; c <= 7; c++) begin
         dmem_ready = (c == 6);
         m_exc      = (c == 3);
         if (c == 7) m_mem_req = 1'b0;
         @(negedge clk);
         checks++;
         if (c <= 5) begin
            if (state !== (c == 0 ? 2'd0 : 2'd2) || en !== 5'b00001 || bub !== 4'b0001 || bus_err !== 1'b0 || exc_flush !== 1'b0) begin
               failures++;
               $display("FAIL mem_wait c=%0d state=%0d en=%b bub=%b bus_err=%b exc=%b", c, state, en, bub, bus_err, exc_flush);
            end
         end else if (c == 6) begin
            if (state !== 2'd2 || en !== 5'b11111 || bub !== 4'b0000 || bus_err !== 1'b0) begin
               failures++;
               $display("FAIL mem_ready state=%0d en=%b bub=%b bus_err=%b expected 2 11111 0000 0", state, en, bub, bus_err);
            end
         end else if (state !== 2'd0) begin
            failures++;
            $display("FAIL mem_after state=%0d expected 0", state);
         end
         tick();
      end
   endtask

   task automatic test_timeout(input bit ready_at_limit);
      idle_inputs();
      m_mem_req = 1'b1;
      for (int c = 0; c <= 65; c++) begin
         dmem_ready = ready_at_limit && (c == 63);
         if (c >= 64) m_mem_req = 1'b0;
         @(negedge clk);
         if (c >= 1 && c <= 62) begin
            checks++;
            if (state !== 2'd2 || bus_err !== 1'b0) begin
               failures++;
               $display("FAIL timeout_wait c=%0d state=%0d bus_err=%b", c, state, bus_err);
            end
         end else if (c == 63) begin
            checks++;
            if (bus_err !== !ready_at_limit || en !== (ready_at_limit ? 5'b11111 : 5'b00001)) begin
               failures++;
               $display("FAIL timeout_edge ready=%0d bus_err=%b en=%b", ready_at_limit, bus_err, en);
            end
         end else if (c == 64) begin
            checks++;
            if (ready_at_limit ? (state !== 2'd0 || exc_flush !== 1'b0)
                               : (state !== 2'd3 || exc_flush !== 1'b1 || en !== 5'b11111 || bub !== 4'b1111 || bus_err !== 1'b0)) begin
               failures++;
               $display("FAIL timeout_err ready=%0d state=%0d exc=%b en=%b bub=%b bus_err=%b", ready_at_limit, state, exc_flush, en, bub, bus_err);
            end
         end else if (c == 65) begin
            checks++;
            if (state !== 2'd0 || exc_flush !== 1'b0) begin
               failures++;
               $display("FAIL timeout_after state=%0d exc=%b expected 0 0", state, exc_flush);
            end
         end
         tick();
      end
   endtask

   task automatic test_exception;
      idle_inputs();
      m_exc = 1'b1;
      e_mdu_start = 1'b1;
      m_mem_req = 1'b1;
      @(negedge clk);
      checks++;
      if (exc_flush !== 1'b1 || bub !== 4'b1111 || en !== 5'b11111 || mdu_busy !== 1'b0 || state !== 2'd0) begin
         failures++;
         $display("FAIL exc_priority exc=%b bub=%b en=%b busy=%b state=%0d", exc_flush, bub, en, mdu_busy, state);
      end
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if (state !== 2'd0 || exc_flush !== 1'b0 || en !== 5'b11111) begin
         failures++;
         $display("FAIL exc_after state=%0d exc=%b en=%b", state, exc_flush, en);
      end
      tick();
   endtask

   task automatic test_hazards;
      idle_inputs();
      d_available = 1'b0;
      imem_ready  = 1'b0;
      @(negedge clk);
      checks++;
      if (en !== 5'b00111 || bub !== 4'b0100) begin
         failures++;
         $display("FAIL load_use en=%b bub=%b expected 00111 0100", en, bub);
      end
      tick();
      d_available = 1'b1;
      @(negedge clk);
      checks++;
      if (en !== 5'b01111 || bub !== 4'b1000) begin
         failures++;
         $display("FAIL imem_wait en=%b bub=%b expected 01111 1000", en, bub);
      end
      tick();
   endtask

   task automatic test_reset_mid_op;
      idle_inputs();
      e_mdu_start = 1'b1;
      tick();
      e_mdu_start = 1'b0;
      @(negedge clk);
      checks++;
      if (state !== 2'd1) begin
         failures++;
         $display("FAIL midop_mdu state=%0d expected 1", state);
      end
      clrn = 1'b0;
      #1;
      checks++;
      if (state !== 2'd0 || en !== 5'b00000 || mdu_busy !== 1'b0) begin
         failures++;
         $display("FAIL midop_abort state=%0d en=%b busy=%b expected 0 00000 0", state, en, mdu_busy);
      end
      tick();
      clrn = 1'b1;
      @(negedge clk);
      checks++;
      if (state !== 2'd0 || en !== 5'b11111) begin
         failures++;
         $display("FAIL midop_release state=%0d en=%b expected 0 11111", state, en);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_mem_wait();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_exception();
      test_hazards();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
